bxclk_scanchain_driver: RTL and testbench
=========================================

Name: bxclk_scanchain_driver

Overview:
- Downstream consumer of bxclks_generators.
- Takes its clk_counter phase and shifts a configuration bitstream into the pixel ASIC scan chain, one bit per bxclk period; data edges land at a programmable counter phase relative to bxclk.
- Words arrive from the AXI register/FIFO side over a valid/ready interface.
- After the last bit it issues a one-bxclk-period scan_load strobe.

Parameters:
- WORD_W, 32, width of each input word.
- NUM_WORDS, 24, words per scan load (768 chain bits).
- CNT_W, 6, width of clk_counter, bxclk_period and data_phase.

Ports:
- clk  input  1  FM clock 400MHz (pl_clk1)
- reset  input  1  synchronous, active-high
- enable  input  1  block enable; same signal that enables bxclks_generators
- clk_counter  input  CNT_W  phase counter from bxclks_generators (0 = idle, else 1..bxclk_period)
- bxclk_period  input  CNT_W  bxclk period in clk ticks
- data_phase  input  CNT_W  counter value at which scan_in changes
- start  input  1  single-cycle request to begin a scan load
- word_data  input  WORD_W  next configuration word; MSB shifted first
- word_valid  input  1  word_data valid
- word_ready  output  1  block accepts word this cycle
- scan_in  output  1  serial data to ASIC
- scan_load  output  1  load strobe to ASIC
- busy  output  1  high from start accept until return to IDLE
- done  output  1  one-cycle pulse at normal completion
- underrun  output  1  sticky; set when a word was not available at a bit boundary; cleared by reset or next accepted start
- bit_count  output  $clog2(NUM_WORDS*WORD_W+1)  bits shifted so far in current load

Behaviour:
- Reset (synchronous): all outputs 0; state IDLE; shift register, holding register and counters cleared.
- tick = enable && clk_counter!=0 && clk_counter==phase_eff.
  - phase_eff = data_phase when 1 <= data_phase <= bxclk_period; otherwise 1.
- States: IDLE, FILL, SHIFT, LOAD, DONE.
- IDLE:
  - start && enable → FILL; busy=1; underrun cleared; bit_count=0.
  - start while busy, or with enable=0, is ignored.
- Word buffering:
  - One holding register (hold_valid) in front of the shift register.
  - word_ready = busy && !hold_valid && words_accepted<NUM_WORDS && state in {FILL,SHIFT}.
  - Transfer occurs on word_valid && word_ready.
  - Same-cycle load of hold into the shift register and accept of a new word is allowed.
- FILL: wait for hold_valid, then for the next tick. On that tick: shift register ← hold, hold_valid cleared, first bit driven → SHIFT.
- Bit drive:
  - On each tick in SHIFT, scan_in <= current MSB, shift left, bit_count+1.
  - scan_in is registered: it changes the cycle after clk_counter==phase_eff.
  - Between ticks scan_in holds its value.
- Word boundary:
  - At a tick where the shift register is exhausted and bits remain, load from hold.
  - If hold is empty: set underrun, scan_in←0 → IDLE, no scan_load, no done.
- Last bit:
  - After bit NUM_WORDS*WORD_W is driven, the next tick → LOAD.
  - In LOAD: scan_in←0, scan_load←1.
  - scan_load stays high until the following tick, i.e. exactly bxclk_period clk cycles; then scan_load←0 → DONE.
- DONE: done=1 for one cycle, busy←0 → IDLE. bit_count holds its final value until the next start.
- enable deasserted in any non-IDLE state:
  - Next cycle → IDLE; scan_in=0, scan_load=0, busy=0; no done.
  - Partial data is discarded; underrun is unchanged.
- bxclk_period or data_phase changing mid-load takes effect at the next comparison; no glitch protection is required.

Decomposition:
- Package bxclk_pkg: CNT_W constant, scan_state_t enum {IDLE,FILL,SHIFT,LOAD,DONE}, TOTAL_BITS function of WORD_W/NUM_WORDS.
- One natural sub-module: bxclk_phase_tick.
  - Computes phase_eff and the registered-compare tick from clk_counter/bxclk_period/data_phase/enable.
  - Reusable for other bxclk-aligned strobes.
- Remaining FSM, holding register and shift register stay in this module.

Test Plan:
- Bench settings: WORD_W=8, NUM_WORDS=2, bxclk_period=10, data_phase=3, bxclk_delay=0. Words 0xA5, 0x3C are pre-queued.
  - Required: scan_in serial 1010010100111100, each bit changing one cycle after clk_counter==3, 10 cycles per bit.
  - Then scan_load high exactly 10 cycles, then done one-cycle pulse; bit_count=16.
- data_phase=0 and data_phase=12 (period 10) → edges at clk_counter==1; same bitstream as above.
- Word 0x3C withheld until after bit 8's tick → underrun=1, busy=0, scan_load never asserts, done=0.
- enable dropped at bit 5 → within one cycle scan_in=0, busy=0. Re-enable plus start with 0xFF,0x00 → clean 1111111100000000 with underrun cleared.
- start pulsed during SHIFT → ignored; bit_count sequence uninterrupted.
- word_valid held high continuously → exactly NUM_WORDS handshakes (word_ready low after second accept); reset asserted mid-LOAD → scan_load=0, all outputs 0 next cycle.

Source files
------------

// File: rtl/bxclk_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bxclk_pkg : shared constants and types for bxclk-aligned scan-chain logic
// Revision  : 1.0
// ---------------------------------------------------------------------------
package bxclk_pkg;

  localparam int CNT_W = 6;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    SHIFT = 3'd2,
    LOAD  = 3'd3,
    DONE  = 3'd4
  } scan_state_t;

  function automatic int total_bits(input int word_w, input int num_words);
    return word_w * num_words;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bxclk_phase_tick.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bxclk_phase_tick : phase-compare strobe aligned to the bxclk phase counter
// Revision         : 1.0
// ---------------------------------------------------------------------------
module bxclk_phase_tick #(
  parameter int CNT_W = bxclk_pkg::CNT_W
) (
  input  logic             enable,
  input  logic [CNT_W-1:0] clk_counter,
  input  logic [CNT_W-1:0] bxclk_period,
  input  logic [CNT_W-1:0] data_phase,
  output logic             tick
);
  import bxclk_pkg::*;

  logic [CNT_W-1:0] phase_eff;

  // Out-of-range phases fall back to the first counter value of the period.
  assign phase_eff = ((data_phase != '0) && (data_phase <= bxclk_period))
                     ? data_phase : CNT_W'(1);

  // Raw compare; users register its effect, so their outputs move one clk later.
  assign tick = enable && (clk_counter != '0) && (clk_counter == phase_eff);

endmodule
`default_nettype wire

// File: rtl/bxclk_scanchain_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bxclk_scanchain_driver : shifts configuration words into the pixel scan chain
// Revision               : 1.0
// ---------------------------------------------------------------------------
module bxclk_scanchain_driver #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 24,
  parameter int CNT_W     = bxclk_pkg::CNT_W
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   enable,
  input  logic [CNT_W-1:0]                       clk_counter,
  input  logic [CNT_W-1:0]                       bxclk_period,
  input  logic [CNT_W-1:0]                       data_phase,
  input  logic                                   start,
  input  logic [WORD_W-1:0]                      word_data,
  input  logic                                   word_valid,
  output logic                                   word_ready,
  output logic                                   scan_in,
  output logic                                   scan_load,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   underrun,
  output logic [$clog2(NUM_WORDS*WORD_W+1)-1:0]  bit_count
);
  import bxclk_pkg::*;

  localparam int TOTAL = total_bits(WORD_W, NUM_WORDS);
  localparam int BC_W  = $clog2(TOTAL + 1);
  localparam int WA_W  = $clog2(NUM_WORDS + 1);
  localparam int BL_W  = $clog2(WORD_W);
  localparam logic [BC_W-1:0] TOTAL_C     = BC_W'(TOTAL);
  localparam logic [WA_W-1:0] NUM_WORDS_C = WA_W'(NUM_WORDS);
  localparam logic [BL_W-1:0] LAST_IDX    = BL_W'(WORD_W - 1);

  scan_state_t       state, state_n;
  logic [WORD_W-1:0] shreg, shreg_n;
  logic [WORD_W-1:0] hold, hold_n;
  logic              hold_valid, hold_valid_n;
  logic [WA_W-1:0]   words_acc, words_acc_n;
  logic [BL_W-1:0]   bits_left, bits_left_n;
  logic [BC_W-1:0]   bit_count_n;
  logic              scan_in_n, scan_load_n, busy_n, done_n, underrun_n;
  logic              tick, accept, load_word;

  bxclk_phase_tick #(.CNT_W(CNT_W)) u_tick (
    .enable       (enable),
    .clk_counter  (clk_counter),
    .bxclk_period (bxclk_period),
    .data_phase   (data_phase),
    .tick         (tick)
  );

  assign word_ready = busy && !hold_valid && (words_acc < NUM_WORDS_C) &&
                      ((state == FILL) || (state == SHIFT));
  assign accept     = word_valid && word_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      hold       <= '0;
      hold_valid <= 1'b0;
      words_acc  <= '0;
      bits_left  <= '0;
      bit_count  <= '0;
      scan_in    <= 1'b0;
      scan_load  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      hold       <= hold_n;
      hold_valid <= hold_valid_n;
      words_acc  <= words_acc_n;
      bits_left  <= bits_left_n;
      bit_count  <= bit_count_n;
      scan_in    <= scan_in_n;
      scan_load  <= scan_load_n;
      busy       <= busy_n;
      done       <= done_n;
      underrun   <= underrun_n;
    end
  end

  always_comb begin
    state_n      = state;
    shreg_n      = shreg;
    hold_n       = hold;
    hold_valid_n = hold_valid;
    words_acc_n  = words_acc;
    bits_left_n  = bits_left;
    bit_count_n  = bit_count;
    scan_in_n    = scan_in;
    scan_load_n  = scan_load;
    busy_n       = busy;
    done_n       = 1'b0;
    underrun_n   = underrun;
    load_word    = 1'b0;

    case (state)
      IDLE: begin
        if (start && enable) begin
          state_n      = FILL;
          busy_n       = 1'b1;
          underrun_n   = 1'b0;
          bit_count_n  = '0;
          words_acc_n  = '0;
          hold_valid_n = 1'b0;
          bits_left_n  = '0;
          scan_in_n    = 1'b0;
        end
      end
      FILL: begin
        if (hold_valid && tick) begin
          load_word = 1'b1;
          state_n   = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (bit_count == TOTAL_C) begin
            state_n     = LOAD;
            scan_in_n   = 1'b0;
            scan_load_n = 1'b1;
          end else if (bits_left == '0) begin
            if (hold_valid) begin
              load_word = 1'b1;
            end else begin
              underrun_n = 1'b1;
              scan_in_n  = 1'b0;
              busy_n     = 1'b0;
              state_n    = IDLE;
            end
          end else begin
            scan_in_n   = shreg[WORD_W-1];
            shreg_n     = {shreg[WORD_W-2:0], 1'b0};
            bits_left_n = bits_left - BL_W'(1);
            bit_count_n = bit_count + BC_W'(1);
          end
        end
      end
      LOAD: begin
        if (tick) begin
          scan_load_n = 1'b0;
          done_n      = 1'b1;
          state_n     = DONE;
        end
      end
      DONE: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Losing enable abandons the load outright; underrun keeps its value.
    if ((state != IDLE) && !enable) begin
      load_word    = 1'b0;
      state_n      = IDLE;
      scan_in_n    = 1'b0;
      scan_load_n  = 1'b0;
      busy_n       = 1'b0;
      done_n       = 1'b0;
      hold_valid_n = 1'b0;
    end

    if (load_word) begin
      scan_in_n    = hold[WORD_W-1];
      shreg_n      = {hold[WORD_W-2:0], 1'b0};
      bits_left_n  = LAST_IDX;
      bit_count_n  = bit_count + BC_W'(1);
      hold_valid_n = 1'b0;
    end

    if (accept && ((state_n == FILL) || (state_n == SHIFT))) begin
      hold_n       = word_data;
      hold_valid_n = 1'b1;
      words_acc_n  = words_acc + WA_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bxclk_scanchain_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_bxclk_scanchain_driver : directed + randomized bench with bitstream model
// Revision                  : 1.0
// ---------------------------------------------------------------------------
module tb_bxclk_scanchain_driver;

  localparam int WORD_W    = 8;
  localparam int NUM_WORDS = 2;
  localparam int CNT_W     = 6;
  localparam int TOTAL     = WORD_W * NUM_WORDS;
  localparam int BCW       = $clog2(TOTAL + 1);

  logic              clk = 1'b0;
  logic              reset, enable, start, word_valid;
  logic [CNT_W-1:0]  clk_counter, bxclk_period, data_phase;
  logic [WORD_W-1:0] word_data;
  logic              word_ready, scan_in, scan_load, busy, done, underrun;
  logic [BCW-1:0]    bit_count;

  int                n_cmp = 0;
  int                n_bad = 0;
  int                hs_count;
  logic [7:0]        wq[$];
  bit                feed_ok;
  logic [15:0]       exp_bits;
  int                cur_pe;

  bxclk_scanchain_driver #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .clk_counter  (clk_counter),
    .bxclk_period (bxclk_period),
    .data_phase   (data_phase),
    .start        (start),
    .word_data    (word_data),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .scan_in      (scan_in),
    .scan_load    (scan_load),
    .busy         (busy),
    .done         (done),
    .underrun     (underrun),
    .bit_count    (bit_count)
  );

  always #5 clk = ~clk;

  // Stand-in for bxclks_generators: counts 1..period while enabled, 0 when idle.
  always @(posedge clk) begin
    if (reset || !enable)
      clk_counter <= '0;
    else if ((clk_counter == '0) || (clk_counter >= bxclk_period))
      clk_counter <= CNT_W'(1);
    else
      clk_counter <= clk_counter + CNT_W'(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic int phase_of(input int dp, input int per);
    return (dp >= 1 && dp <= per) ? dp : 1;
  endfunction

  task automatic step();
    logic hs;
    hs = word_valid && word_ready;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (hs) begin
      hs_count++;
      void'(wq.pop_front());
    end
    word_valid = feed_ok && (wq.size() > 0);
    word_data  = (wq.size() > 0) ? wq[0] : 8'h00;
  endtask

  task automatic wait_phase(input int need_hs);
    int n;
    n = 0;
    while (!((int'(clk_counter) == cur_pe) && (hs_count >= need_hs)) && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) begin
      n_cmp++;
      assert (n < 200) else begin
        n_bad++;
        $error("FAIL wait_tick: observed no phase match expected match within 200 cycles");
      end
    end
  endtask

  task automatic begin_load(input logic [7:0] w0, input logic [7:0] w1, input int dp, input int nfed);
    data_phase = CNT_W'(dp);
    cur_pe     = phase_of(dp, int'(bxclk_period));
    exp_bits   = {w0, w1};
    wq.delete();
    wq.push_back(w0);
    if (nfed > 1) wq.push_back(w1);
    hs_count   = 0;
    feed_ok    = 1'b1;
    word_valid = 1'b1;
    word_data  = w0;
    start      = 1'b1;
    step();
    chk("start_busy", busy, 1);
    chk("start_underrun", underrun, 0);
    chk("start_bitcount", bit_count, 0);
  endtask

  task automatic shift_bits(input int first, input int last);
    for (int k = first; k <= last; k++) begin
      wait_phase(k / WORD_W + 1);
      chk("hold_prev", scan_in, (k == 0) ? 1'b0 : exp_bits[16 - k]);
      step();
      chk("bit", scan_in, exp_bits[15 - k]);
      chk("bit_count", bit_count, k + 1);
    end
  endtask

  task automatic finish_load();
    int n;
    wait_phase(0);
    chk("load_pre", scan_load, 0);
    step();
    chk("load_rise", scan_load, 1);
    chk("load_scan_in", scan_in, 0);
    chk("load_done_early", done, 0);
    n = 1;
    while (n < 100) begin
      step();
      if (!scan_load) break;
      n++;
    end
    chk("load_len", n, int'(bxclk_period));
    chk("done_pulse", done, 1);
    step();
    chk("done_clear", done, 0);
    chk("end_busy", busy, 0);
    chk("end_bitcount", bit_count, TOTAL);
  endtask

  initial begin
    bit seen;
    reset = 1'b1; enable = 1'b0; start = 1'b0; word_valid = 1'b0; word_data = '0;
    bxclk_period = CNT_W'(10); data_phase = CNT_W'(3);
    feed_ok = 1'b0; hs_count = 0; cur_pe = 3; exp_bits = '0;
    repeat (3) step();
    chk("rst_scan_in", scan_in, 0);
    chk("rst_scan_load", scan_load, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_bitcount", bit_count, 0);
    chk("rst_ready", word_ready, 0);
    reset = 1'b0; enable = 1'b1;
    repeat (2) step();

    // Nominal load, then out-of-range phases that fall back to counter value 1.
    begin_load(8'hA5, 8'h3C, 3, 2);  shift_bits(0, 15); finish_load();
    begin_load(8'hA5, 8'h3C, 0, 2);  shift_bits(0, 15); finish_load();
    begin_load(8'hA5, 8'h3C, 12, 2); shift_bits(0, 15); finish_load();

    // A start pulse mid-shift must not disturb the load.
    begin_load(8'hA5, 8'h3C, 3, 2);
    shift_bits(0, 5);
    start = 1'b1;
    step();
    chk("start_ignored_busy", busy, 1);
    shift_bits(6, 15);
    finish_load();

    for (int r = 0; r < 4; r++) begin
      bxclk_period = CNT_W'($urandom_range(4, 12));
      begin_load(8'($urandom), 8'($urandom), int'($urandom_range(0, 15)), 2);
      shift_bits(0, 15);
      finish_load();
    end
    bxclk_period = CNT_W'(10);

    // Second word withheld: the word boundary finds the holding register empty.
    begin_load(8'hA5, 8'h3C, 3, 1);
    shift_bits(0, 7);
    wait_phase(1);
    chk("ur_hold_prev", scan_in, exp_bits[8]);
    step();
    chk("ur_flag", underrun, 1);
    chk("ur_busy", busy, 0);
    chk("ur_scan_in", scan_in, 0);
    chk("ur_bitcount", bit_count, 8);
    wq.push_back(8'h3C);
    seen = 1'b0;
    repeat (30) begin
      step();
      if (scan_load || done) seen = 1'b1;
    end
    chk("ur_no_load_done", seen, 0);
    chk("ur_handshakes", hs_count, 1);

    // Enable dropped after bit 5, then a clean load with fresh words.
    begin_load(8'hF8, 8'h3C, 3, 2);
    shift_bits(0, 4);
    enable = 1'b0;
    step();
    chk("drop_scan_in", scan_in, 0);
    chk("drop_busy", busy, 0);
    chk("drop_scan_load", scan_load, 0);
    chk("drop_done", done, 0);
    chk("drop_underrun", underrun, 0);
    enable = 1'b1;
    repeat (3) step();
    begin_load(8'hFF, 8'h00, 3, 2); shift_bits(0, 15); finish_load();

    // word_valid never drops: only NUM_WORDS words may be taken; reset hits mid-LOAD.
    begin_load(8'hA5, 8'h3C, 3, 2);
    wq.push_back(8'h77);
    shift_bits(0, 15);
    chk("cont_handshakes", hs_count, NUM_WORDS);
    chk("cont_ready_low", word_ready, 0);
    chk("cont_valid_high", word_valid, 1);
    wait_phase(0);
    step();
    chk("cont_load", scan_load, 1);
    repeat (3) step();
    reset = 1'b1;
    step();
    chk("mid_rst_scan_load", scan_load, 0);
    chk("mid_rst_scan_in", scan_in, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_underrun", underrun, 0);
    chk("mid_rst_bitcount", bit_count, 0);
    chk("mid_rst_ready", word_ready, 0);
    reset = 1'b0;
    feed_ok = 1'b0;
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
